// File: rtl/cla_seq_pkg.sv
// Shared constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/CLA_4bit.sv
// Existing 4-bit carry-lookahead slice: all carries from generate/propagate terms.
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// Wide adder reusing one CLA_4bit slice, one nibble per clock, LSB nibble first.
// States: IDLE accept operands | RUN add nibble idx | DONE hold result until taken
module cla_nibble_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t state, state_nx;

  logic [W-1:0]        a_reg, b_reg, sum_reg;
  logic                carry, cout_reg;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                c_nib;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  CLA_4bit u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)       state_nx = RUN;
      RUN:     if (idx == IDX_LAST) state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            idx     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
          end
          carry <= c_nib;
          if (idx == IDX_LAST) begin
            cout_reg <= c_nib;
            idx      <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Bench for cla_nibble_seq_adder: lane 0 has NIBBLES=4, lane 1 has NIBBLES=1.
module tb_cla_nibble_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid_v, out_ready_v, cin_v;
  logic [1:0]  in_ready_v, out_valid_v, busy_v, cout_v;
  logic [15:0] a_s [2];
  logic [15:0] b_s [2];
  logic [15:0] sum_s [2];
  logic [15:0] sum0;
  logic [3:0]  sum1;

  always #5 clk = ~clk;

  cla_nibble_seq_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum0), .cout(cout_v[0]), .busy(busy_v[0])
  );

  cla_nibble_seq_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_s[1][3:0]), .b(b_s[1][3:0]), .cin(cin_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_v[1]), .busy(busy_v[1])
  );

  always_comb begin
    sum_s[0] = sum0;
    sum_s[1] = {12'h000, sum1};
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: a transaction is accepted when idle, its result is
  // a+b+cin, and it must be presented from NIBBLES edges after acceptance
  // until the consumer takes it.
  bit          m_busy  [2];
  bit          m_clean [2];
  int          m_acc   [2];
  logic [15:0] m_sum   [2];
  logic        m_cout  [2];
  logic [16:0] m_tmp;

  function automatic int nib_of(input int l);
    return (l == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] mask_of(input int l);
    return (l == 0) ? 16'hFFFF : 16'h000F;
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %0h, expected %0h (edge %0d)", nm, l, act, exp, cyc);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 1'b0; m_clean[l] = 1'b0; m_acc[l] = 0;
      m_sum[l] = '0; m_cout[l] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) chk_en = 1'b1;
      for (int l = 0; l < 2; l++) begin
        if (rst) begin
          m_busy[l]  = 1'b0;
          m_clean[l] = 1'b1;
        end else if (!m_busy[l]) begin
          if (in_valid_v[l]) begin
            m_tmp = 17'(a_s[l] & mask_of(l)) + 17'(b_s[l] & mask_of(l)) + 17'(cin_v[l]);
            m_sum[l]   = m_tmp[15:0] & mask_of(l);
            m_cout[l]  = (l == 0) ? m_tmp[16] : m_tmp[4];
            m_busy[l]  = 1'b1;
            m_acc[l]   = cyc;
            m_clean[l] = 1'b0;
          end
        end else if ((cyc - m_acc[l] > nib_of(l)) && out_ready_v[l]) begin
          m_busy[l] = 1'b0;
        end
      end
    end
  end

  initial begin
    bit ov_exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int l = 0; l < 2; l++) begin
          ov_exp = m_busy[l] && (cyc - m_acc[l] >= nib_of(l));
          chk("in_ready", l, 32'(in_ready_v[l]), 32'(!m_busy[l]));
          chk("busy", l, 32'(busy_v[l]), 32'(m_busy[l]));
          chk("out_valid", l, 32'(out_valid_v[l]), 32'(ov_exp));
          if (ov_exp || m_clean[l]) begin
            chk("sum", l, 32'(sum_s[l]), ov_exp ? 32'(m_sum[l]) : 32'h0);
            chk("cout", l, 32'(cout_v[l]), ov_exp ? 32'(m_cout[l]) : 32'h0);
          end
        end
      end
    end
  end

  task automatic send(input int l, input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, output int acc);
    @(negedge clk);
    a_s[l] = av; b_s[l] = bv; cin_v[l] = cv; in_valid_v[l] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready_v[l]) break;
      @(negedge clk);
    end
    chk("send_ready", l, 32'(in_ready_v[l]), 32'h1);
    acc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[l] = 1'b0;
  endtask

  task automatic wait_out(input int l, output int at);
    for (int k = 0; k < 100; k++) begin
      if (out_valid_v[l]) break;
      @(negedge clk);
    end
    chk("out_valid_seen", l, 32'(out_valid_v[l]), 32'h1);
    at = cyc;
  endtask

  task automatic run_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec);
    int acc, t;
    out_ready_v[0] = 1'b1;
    send(0, av, bv, cv, acc);
    chk({nm, "_model"}, 0, 32'({m_cout[0], m_sum[0]}), 32'({ec, es}));
    wait_out(0, t);
    chk({nm, "_latency"}, 0, 32'(t - acc), 32'd4);
    chk({nm, "_sum"}, 0, 32'(sum_s[0]), 32'(es));
    chk({nm, "_cout"}, 0, 32'(cout_v[0]), 32'(ec));
    @(negedge clk);
    chk({nm, "_in_ready_back"}, 0, 32'(in_ready_v[0]), 32'h1);
    chk({nm, "_out_valid_drop"}, 0, 32'(out_valid_v[0]), 32'h0);
  endtask

  task automatic rand_run(input int l, input int nops);
    int ops = 0;
    int guard = 0;
    bit acc_next = 1'b0;
    in_valid_v[l] = 1'b0;
    while (ops < nops && guard < 40000) begin
      @(negedge clk);
      if (in_valid_v[l] && acc_next) begin
        in_valid_v[l] = 1'b0;
        ops++;
      end
      if (!in_valid_v[l] && ops < nops && $urandom_range(0, 1) == 1) begin
        a_s[l]        = 16'($urandom()) & mask_of(l);
        b_s[l]        = 16'($urandom()) & mask_of(l);
        cin_v[l]      = 1'($urandom_range(0, 1));
        in_valid_v[l] = 1'b1;
      end
      acc_next = in_valid_v[l] && in_ready_v[l];
      out_ready_v[l] = ($urandom_range(0, 3) != 0);
      guard++;
    end
    chk("rand_ops_done", l, 32'(ops), 32'(nops));
    in_valid_v[l]  = 1'b0;
    out_ready_v[l] = 1'b1;
    repeat (12) @(negedge clk);
    chk("rand_drained", l, 32'(in_ready_v[l]), 32'h1);
  endtask

  initial begin
    int acc, t;
    rst = 1'b1;
    in_valid_v = 2'b01; out_ready_v = 2'b00; cin_v = 2'b00;
    a_s[0] = 16'h1234; b_s[0] = 16'h4321; a_s[1] = '0; b_s[1] = '0;

    // in_valid during reset must not latch anything
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid_v = 2'b00;
    chk("reset_in_ready", 0, 32'(in_ready_v[0]), 32'h1);
    chk("reset_out_valid", 0, 32'(out_valid_v[0]), 32'h0);
    chk("reset_busy", 0, 32'(busy_v[0]), 32'h0);
    chk("reset_sum", 0, 32'(sum_s[0]), 32'h0);

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("wrap_b1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("wrap_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    out_ready_v[0] = 1'b0;
    send(0, 16'hA5A5, 16'h5A5A, 1'b0, acc);
    wait_out(0, t);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 0, 32'(out_valid_v[0]), 32'h1);
      chk("bp_sum", 0, 32'(sum_s[0]), 32'h0000FFFF);
      chk("bp_cout", 0, 32'(cout_v[0]), 32'h0);
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    chk("bp_idle_next", 0, 32'(in_ready_v[0]), 32'h1);

    send(0, 16'h1234, 16'h4321, 1'b0, acc);
    a_s[0] = 16'h0F0F; in_valid_v[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid_v[0]) break;
      chk("busy_reject_ready", 0, 32'(in_ready_v[0]), 32'h0);
      @(negedge clk);
    end
    chk("busy_reject_done_ready", 0, 32'(in_ready_v[0]), 32'h0);
    chk("busy_reject_sum", 0, 32'(sum_s[0]), 32'h00005555);
    in_valid_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_reject_no_extra", 0, 32'(out_valid_v[0]), 32'h0);

    send(0, 16'hFFFF, 16'h0001, 1'b0, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 0, 32'(in_ready_v[0]), 32'h1);
    chk("midrst_out_valid", 0, 32'(out_valid_v[0]), 32'h0);
    chk("midrst_sum", 0, 32'(sum_s[0]), 32'h0);
    chk("midrst_cout", 0, 32'(cout_v[0]), 32'h0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_emit", 0, 32'(out_valid_v[0]), 32'h0);
    end
    run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    rand_run(0, 1000);
    rand_run(1, 1000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Sequential wide adder that reuses one existing 4-bit carry-lookahead slice (CLA_4bit) over NIBBLES cycles.
- Adds two 4*NIBBLES-bit operands one nibble per clock, least-significant nibble first.
- The carry between nibbles is held in a register.
- Trades latency for area; sits between an operand producer and a result consumer with valid/ready handshakes on both sides.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  W  operand A, sampled on input handshake
- b  input  W  operand B, sampled on input handshake
- cin  input  1  carry-in to nibble 0, sampled on input handshake
- out_valid  output  1  result available (DONE only)
- out_ready  input  1  consumer accepts result
- sum  output  W  result sum, stable while out_valid
- cout  output  1  carry out of top nibble, stable while out_valid
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry reg=0, a/b operand regs=0, sum=0, cout=0. Resulting outputs: in_ready=1, out_valid=0, busy=0. Reset overrides every other input, including mid-RUN or mid-DONE; a partial result is discarded, never emitted.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid at an edge:
    - latch a, b;
    - carry reg<=cin, idx<=0;
    - clear sum to 0;
    - go to RUN.
  - RUN: in_ready=0. Each edge:
    - CLA slice computes a[4*idx+:4] + b[4*idx+:4] + carry reg;
    - slice sum is written into sum[4*idx+:4];
    - carry reg<=slice cout;
    - idx<=idx+1.
    - On the edge where idx==NIBBLES-1: cout<=slice cout, go to DONE, idx<=0.
  - DONE: out_valid=1, sum/cout held constant. On out_ready at an edge: go to IDLE. out_valid drops on the next cycle.
- Latency: the input handshake edge is edge 0. out_valid is high after edge NIBBLES. Throughput is one operation per NIBBLES+2 cycles minimum.
- No overlap: a new operand set is not accepted in the same cycle as the output handshake. in_ready asserts the cycle after DONE exits.
- in_valid while busy is ignored; the caller keeps it asserted until in_ready.
- out_ready while not in DONE is ignored.
- Arithmetic: {cout,sum} = a + b + cin exactly, modulo 2^(W+1); unsigned.
- Wrap-around: all-ones + 1 gives sum=0, cout=1.
- NIBBLES=1: RUN lasts one cycle; idx is held at 0.
- idx width: clog2(NIBBLES) bits, minimum 1.
- Simultaneous in_valid and rst: reset wins, nothing is latched.

Decomposition:
- Shared package cla_seq_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module instance: the existing CLA_4bit (a, b, cin, sum, cout) as the per-nibble datapath.
- Nibble select mux and carry register stay in this module.

Test Plan:
- NIBBLES=4, cin=0, a=16'h1234, b=16'h4321, out_ready=1 -> out_valid after exactly 4 edges; sum=16'h5555, cout=0; in_ready returns one cycle after the output handshake.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (ripple across all nibbles through the carry reg). Repeat with a=16'hFFFF, b=16'h0000, cin=1 -> same result.
- Backpressure: a=16'hA5A5, b=16'h5A5A, cin=0, out_ready held low 5 cycles in DONE -> sum=16'hFFFF, cout=0 stable and out_valid high for all 5 cycles. On raising out_ready, IDLE is entered next cycle.
- Busy rejection: during RUN, drive in_valid=1 with a=16'h0F0F -> ignored, first result unchanged, in_ready=0 throughout RUN/DONE.
- Reset mid-operation: assert rst for one edge at idx=2 of a 16'hFFFF+16'h0001 add -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0, and no result is ever emitted. A following 16'h0003+16'h0004 add returns 16'h0007.
- Random sweep with NIBBLES=1 and NIBBLES=4: 1000 random a/b/cin with random out_ready stalls -> every result equals a+b+cin; the scoreboard checks latency = NIBBLES edges.
